// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file dump reader.
// The state enum and a modulo-NumRegs index increment that also works when NumRegs is not a power of two.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

  // Wraps by explicit compare so non-power-of-2 register counts roll over correctly.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num_regs);
    return (idx == num_regs - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive, optionally wrapping index range of a register file and streams each
// word out on a valid/ready port tagged with its index and a last flag.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned NumRegs    = 16,
  parameter int unsigned IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IndexWidth-1:0] first_idx,
  input  logic [IndexWidth-1:0] last_idx,
  input  logic                  abort,
  output logic [IndexWidth-1:0] rd_addr,
  input  logic [DataWidth-1:0]  rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DataWidth-1:0]  m_data,
  output logic [IndexWidth-1:0] m_index,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  // Stream handshake: a word transfers on every rising edge where m_valid and m_ready are both
  // high; while m_valid is high and m_ready is low, m_data/m_index/m_last hold stable.

  localparam logic [IndexWidth:0] NumRegsW = (IndexWidth + 1)'(NumRegs);

  state_e                state_q, state_d;
  logic [IndexWidth-1:0] cur_idx_q, cur_idx_d;
  logic [IndexWidth-1:0] last_q, last_d;
  logic [DataWidth-1:0]  m_data_q, m_data_d;
  logic [IndexWidth-1:0] m_index_q, m_index_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [IndexWidth-1:0] nxt_idx;
  logic                  handshake;
  logic                  range_ok;

  assign nxt_idx   = IndexWidth'(wrap_inc(32'(cur_idx_q), NumRegs));
  assign handshake = m_valid_q & m_ready;
  assign range_ok  = ({1'b0, first_idx} < NumRegsW) && ({1'b0, last_idx} < NumRegsW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_idx_q <= '0;
      last_q    <= '0;
      m_data_q  <= '0;
      m_index_q <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      last_q    <= last_d;
      m_data_q  <= m_data_d;
      m_index_q <= m_index_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    last_d    = last_q;
    m_data_d  = m_data_q;
    m_index_d = m_index_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_addr   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (range_ok) begin
            cur_idx_d = first_idx;
            last_d    = last_idx;
            state_d   = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        rd_addr   = cur_idx_q;
        m_data_d  = rd_data;
        m_index_d = cur_idx_q;
        m_last_d  = (cur_idx_q == last_q);
        m_valid_d = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        // Prefetch the following word so a handshake can reload the output every cycle.
        rd_addr = nxt_idx;
        if (handshake) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            m_data_d  = rd_data;
            m_index_d = nxt_idx;
            cur_idx_d = nxt_idx;
            m_last_d  = (nxt_idx == last_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = IDLE;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cur_idx_d = cur_idx_q;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_index   = m_index_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: 16-entry and 12-entry instances reading a
// modelled register file preloaded with regs[i] = i*0x11.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;

  // 16-entry instance
  logic       start = 1'b0, abort = 1'b0, m_ready = 1'b0;
  logic [3:0] first_idx = '0, last_idx = '0;
  logic [3:0] rd_addr, m_index;
  logic [7:0] rd_data, m_data;
  logic       m_valid, m_last, busy, done, err;
  logic [1:0] dbg_state;

  // 12-entry instance
  logic       s12_start = 1'b0, s12_abort = 1'b0, s12_ready = 1'b0;
  logic [3:0] s12_first = '0, s12_last = '0;
  logic [3:0] s12_rd_addr, s12_index;
  logic [7:0] s12_rd_data, s12_data;
  logic       s12_valid, s12_mlast, s12_busy, s12_done, s12_err;
  logic [1:0] s12_state;

  always #5 clk = ~clk;

  assign rd_data     = {4'h0, rd_addr} * 8'h11;
  assign s12_rd_data = {4'h0, s12_rd_addr} * 8'h11;

  regfile_dump_reader #(.DataWidth(8), .NumRegs(16)) dut (
    .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  regfile_dump_reader #(.DataWidth(8), .NumRegs(12)) dut12 (
    .clk(clk), .rst(rst), .start(s12_start), .first_idx(s12_first), .last_idx(s12_last),
    .abort(s12_abort), .rd_addr(s12_rd_addr), .rd_data(s12_rd_data), .m_valid(s12_valid),
    .m_ready(s12_ready), .m_data(s12_data), .m_index(s12_index), .m_last(s12_mlast),
    .busy(s12_busy), .done(s12_done), .err(s12_err), .dbg_state(s12_state)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] f, input logic [3:0] l);
    start = 1'b1; first_idx = f; last_idx = l;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({m_valid, m_data, m_index, m_last, busy, done, err, dbg_state, rd_addr} !== 23'd0) begin
      $display("FAIL reset16 got v=%b d=%h i=%h l=%b b=%b dn=%b e=%b s=%h a=%h exp all 0",
               m_valid, m_data, m_index, m_last, busy, done, err, dbg_state, rd_addr);
      errors++;
    end
    checks++;
    if ({s12_valid, s12_busy, s12_done, s12_err, s12_state} !== 6'd0) begin
      $display("FAIL reset12 got v=%b b=%b dn=%b e=%b s=%h exp 0", s12_valid, s12_busy,
               s12_done, s12_err, s12_state);
      errors++;
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    m_ready = 1'b1;
    do_start(4'd2, 4'd5);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL basic_load got v=%b b=%b exp v=0 b=1", m_valid, busy);
      errors++;
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({m_valid, m_data, m_index, m_last, done} !== {1'b1, exp_d[i], 4'(2 + i), i == 3, 1'b0}) begin
        $display("FAIL basic_word%0d got v=%b d=%h i=%h l=%b dn=%b exp v=1 d=%h i=%h l=%b dn=0",
                 i, m_valid, m_data, m_index, m_last, done, exp_d[i], 4'(2 + i), i == 3);
        errors++;
      end
      tick();
    end
    checks++;
    if ({done, busy, m_valid, m_last} !== 4'b1000) begin
      $display("FAIL basic_done got dn=%b b=%b v=%b l=%b exp 1000", done, busy, m_valid, m_last);
      errors++;
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL basic_done_pulse got dn=%b exp 0", done);
      errors++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d [4] = '{8'hEE, 8'hFF, 8'h00, 8'h11};
    logic [3:0] exp_i [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    int         n_done = 0;
    m_ready = 1'b1;
    do_start(4'd14, 4'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({m_valid, m_data, m_index, m_last} !== {1'b1, exp_d[i], exp_i[i], i == 3}) begin
        $display("FAIL wrap_word%0d got v=%b d=%h i=%h l=%b exp v=1 d=%h i=%h l=%b",
                 i, m_valid, m_data, m_index, m_last, exp_d[i], exp_i[i], i == 3);
        errors++;
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    checks++;
    if (n_done != 1) begin
      $display("FAIL wrap_done_count got %0d exp 1", n_done);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    do_start(4'd3, 4'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({m_valid, m_data, m_index, m_last, done} !== {1'b1, 8'h33, 4'd3, 1'b1, 1'b0}) begin
        $display("FAIL bp_hold%0d got v=%b d=%h i=%h l=%b dn=%b exp v=1 d=33 i=3 l=1 dn=0",
                 i, m_valid, m_data, m_index, m_last, done);
        errors++;
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if ({done, m_valid, busy} !== 3'b100) begin
      $display("FAIL bp_done got dn=%b v=%b b=%b exp 100", done, m_valid, busy);
      errors++;
    end
    tick();
    checks++;
    if ({done, m_valid} !== 2'b00) begin
      $display("FAIL bp_single got dn=%b v=%b exp 00", done, m_valid);
      errors++;
    end
  endtask

  task automatic test_abort();
    int n_done = 0;
    m_ready = 1'b1;
    do_start(4'd0, 4'd15);
    tick();
    tick();
    tick();
    checks++;
    if ({m_valid, m_data, m_index} !== {1'b1, 8'h22, 4'd2}) begin
      $display("FAIL abort_pre got v=%b d=%h i=%h exp v=1 d=22 i=2", m_valid, m_data, m_index);
      errors++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({m_valid, m_last, busy, done} !== 4'b0000) begin
      $display("FAIL abort_clear got v=%b l=%b b=%b dn=%b exp 0000", m_valid, m_last, busy, done);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || m_valid === 1'b1) n_done++;
      tick();
    end
    checks++;
    if (n_done != 0) begin
      $display("FAIL abort_quiet got %0d active cycles exp 0", n_done);
      errors++;
    end
    // Abort together with start in IDLE: start dropped, no err.
    abort = 1'b1;
    do_start(4'd4, 4'd4);
    abort = 1'b0;
    checks++;
    if ({busy, err} !== 2'b00) begin
      $display("FAIL abort_start got b=%b e=%b exp 00", busy, err);
      errors++;
    end
    do_start(4'd7, 4'd7);
    tick();
    checks++;
    if ({m_valid, m_data, m_index, m_last} !== {1'b1, 8'h77, 4'd7, 1'b1}) begin
      $display("FAIL abort_restart got v=%b d=%h i=%h l=%b exp v=1 d=77 i=7 l=1",
               m_valid, m_data, m_index, m_last);
      errors++;
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL abort_restart_done got dn=%b exp 1", done);
      errors++;
    end
    tick();
  endtask

  task automatic test_invalid_start();
    logic [7:0] exp_d [4] = '{8'hAA, 8'hBB, 8'h00, 8'h11};
    logic [3:0] exp_i [4] = '{4'd10, 4'd11, 4'd0, 4'd1};
    s12_start = 1'b1; s12_first = 4'd0; s12_last = 4'd13;
    tick();
    s12_start = 1'b0;
    checks++;
    if ({s12_err, s12_busy, s12_valid, s12_done} !== 4'b1000) begin
      $display("FAIL inv_err got e=%b b=%b v=%b dn=%b exp 1000", s12_err, s12_busy, s12_valid, s12_done);
      errors++;
    end
    tick();
    checks++;
    if ({s12_err, s12_busy, s12_valid} !== 3'b000) begin
      $display("FAIL inv_err_pulse got e=%b b=%b v=%b exp 000", s12_err, s12_busy, s12_valid);
      errors++;
    end
    // Wrap on a non-power-of-two file: 11 rolls over to 0.
    s12_ready = 1'b1;
    s12_start = 1'b1; s12_first = 4'd10; s12_last = 4'd1;
    tick();
    s12_start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({s12_valid, s12_data, s12_index, s12_mlast} !== {1'b1, exp_d[i], exp_i[i], i == 3}) begin
        $display("FAIL wrap12_word%0d got v=%b d=%h i=%h l=%b exp v=1 d=%h i=%h l=%b",
                 i, s12_valid, s12_data, s12_index, s12_mlast, exp_d[i], exp_i[i], i == 3);
        errors++;
      end
      tick();
    end
    checks++;
    if ({s12_done, s12_err} !== 2'b10) begin
      $display("FAIL wrap12_done got dn=%b e=%b exp 10", s12_done, s12_err);
      errors++;
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] exp_d [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    m_ready = 1'b1;
    do_start(4'd2, 4'd5);
    tick();
    for (int i = 0; i < 4; i++) begin
      start = (i < 2); first_idx = 4'd9; last_idx = 4'd9;
      checks++;
      if ({m_valid, m_data, m_index, m_last, err} !== {1'b1, exp_d[i], 4'(2 + i), i == 3, 1'b0}) begin
        $display("FAIL busy_word%0d got v=%b d=%h i=%h l=%b e=%b exp v=1 d=%h i=%h l=%b e=0",
                 i, m_valid, m_data, m_index, m_last, err, exp_d[i], 4'(2 + i), i == 3);
        errors++;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if ({done, busy, err} !== 3'b100) begin
      $display("FAIL busy_done got dn=%b b=%b e=%b exp 100", done, busy, err);
      errors++;
    end
    tick();
  endtask

  task automatic test_reset_mid_send();
    m_ready = 1'b0;
    do_start(4'd4, 4'd6);
    tick();
    checks++;
    if ({m_valid, m_data} !== {1'b1, 8'h44}) begin
      $display("FAIL rst_pre got v=%b d=%h exp v=1 d=44", m_valid, m_data);
      errors++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_data, m_index, m_last, busy, done, err, rd_addr} !== 21'd0) begin
      $display("FAIL rst_async got v=%b d=%h i=%h l=%b b=%b dn=%b e=%b a=%h exp all 0",
               m_valid, m_data, m_index, m_last, busy, done, err, rd_addr);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    m_ready = 1'b1;
    do_start(4'd1, 4'd2);
    tick();
    checks++;
    if ({m_valid, m_data, m_index, m_last} !== {1'b1, 8'h11, 4'd1, 1'b0}) begin
      $display("FAIL rst_after0 got v=%b d=%h i=%h l=%b exp v=1 d=11 i=1 l=0",
               m_valid, m_data, m_index, m_last);
      errors++;
    end
    tick();
    checks++;
    if ({m_valid, m_data, m_index, m_last} !== {1'b1, 8'h22, 4'd2, 1'b1}) begin
      $display("FAIL rst_after1 got v=%b d=%h i=%h l=%b exp v=1 d=22 i=2 l=1",
               m_valid, m_data, m_index, m_last);
      errors++;
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b10) begin
      $display("FAIL rst_after_done got dn=%b b=%b exp 10", done, busy);
      errors++;
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abort();
    test_invalid_start();
    test_start_while_busy();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Read-side sequencer for the team's register file. On a start pulse it walks an inclusive index range, drives the register file's combinational read-address port, and streams each word out on a valid/ready interface tagged with its index and a last flag. Used for debug dumps, context save and register scrubbing without touching the core's read ports.

Parameters:
DataWidth, 8, width of each register word
NumRegs, 16, number of registers in the attached file (need not be a power of 2)
IndexWidth, $clog2(NumRegs), width of index/address fields

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a dump
first_idx  in  IndexWidth  first index of range, sampled with start
last_idx  in  IndexWidth  last index of range (inclusive), sampled with start
abort  in  1  cancel any dump in progress
rd_addr  out  IndexWidth  read address to register file
rd_data  in  DataWidth  combinational read data for rd_addr
m_valid  out  1  stream word valid
m_ready  in  1  downstream accept
m_data  out  DataWidth  stream word
m_index  out  IndexWidth  register index of m_data
m_last  out  1  marks final word of range
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse after final word accepted
err  out  1  one-cycle pulse when start rejected for out-of-range index

Behaviour:
- Reset (async, immediate): state IDLE; m_valid, m_data, m_index, m_last, done, err, cur_idx, last_q all 0.
- States: IDLE, LOAD, SEND. busy = (state != IDLE).
- Index increment: nxt_idx = (cur_idx == NumRegs-1) ? 0 : cur_idx+1. Explicit compare, not power-of-2 overflow.
- rd_addr: IDLE = 0; LOAD = cur_idx; SEND = nxt_idx.
- IDLE:
  - start with first_idx and last_idx < NumRegs: latch cur_idx=first_idx, last_q=last_idx, go LOAD.
  - start with either index >= NumRegs: err=1 for one cycle, stay IDLE.
- LOAD (one cycle): m_data<=rd_data, m_index<=cur_idx, m_last<=(cur_idx==last_q), m_valid<=1, go SEND.
  - Latency: m_valid is high in the second cycle after the cycle start is sampled.
- SEND, handshake = m_valid & m_ready:
  - No handshake: m_data, m_index, m_last held stable.
  - Handshake with !m_last: m_data<=rd_data, m_index<=nxt_idx, cur_idx<=nxt_idx, m_last<=(nxt_idx==last_q), m_valid stays 1. Full throughput, one word per cycle.
  - Handshake with m_last: m_valid<=0, m_last<=0, done<=1 for one cycle, go IDLE.
- Range semantics:
  - first_idx > last_idx wraps through NumRegs-1 to 0.
  - first_idx == last_idx yields exactly one word.
  - Word count = ((last-first) mod NumRegs) + 1.
- Priority: abort > handshake > start.
  - abort in any state: next edge go IDLE, m_valid/m_last cleared, no done.
  - abort with start in IDLE: start ignored, no err.
- start while busy: ignored, no err.
- Read data reflects the register file's current read, including its write-bypass value if a write to that index is concurrent. No coherency beyond that.
- done and err are never high simultaneously.

Decomposition:
- Package regfile_pkg holds the state enum (IDLE, LOAD, SEND) and a wrap-increment function parameterised on NumRegs.
- Single module, no sub-module. The block is one FSM with a datapath register.

Test Plan:
All scenarios use NumRegs=16 unless stated, with the register file preloaded regs[i]=i*0x11 (reg0 reads 0x00).
1. first=2, last=5, m_ready=1 constant -> data 0x22,0x33,0x44,0x55 on 4 consecutive cycles; m_index 2..5; m_last only on 0x55; done one cycle later; busy drops with done.
2. Wrap: first=14, last=1, m_ready=1 -> 0xEE,0xFF,0x00,0x11; m_last on index 1; done once.
3. Backpressure: first=3, last=3, m_ready=0 for 5 cycles then 1 -> m_valid=1, m_data=0x33, m_index=3, m_last=1 held stable all 5 cycles; single handshake; done pulse.
4. Abort: first=0, last=15, abort after 2nd handshake -> m_valid=0 next cycle, busy=0, done never asserts; a following start first=7, last=7 returns 0x77.
5. Invalid/ignored start:
   - NumRegs=12 instance with last=13 -> err pulse, busy stays 0, m_valid stays 0.
   - start during an active dump -> no effect on the stream.
6. Reset mid-SEND (m_valid=1, m_data=0x44) -> all outputs 0 immediately without a clock edge; after release, start first=1, last=2 yields 0x11, 0x22.
